// File: rtl/lb_host_master_pkg.sv
// lb_host_master_pkg: shared types and constants for the local-bus host master.
//   lb_state_e : FSM encoding IDLE -> ISSUE -> WAIT -> RESP
//   lb_cmd_t   : latched command {wr, addr, wdata}
//   lb_rsp_t   : registered response {wr, rdata, err}
//   TMR_W      : width of the optional timeout counter (LB_TIMEOUT_EN builds)
// The struct fields are sized to the default bus widths. The top module casts
// into and out of them.
package lb_host_master_pkg;

  localparam int unsigned TMR_W         = 16;
  localparam int unsigned LB_PKG_ADDR_W = 16;
  localparam int unsigned LB_PKG_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lb_state_e;

  typedef struct packed {
    logic                     wr;
    logic [LB_PKG_ADDR_W-1:0] addr;
    logic [LB_PKG_DATA_W-1:0] wdata;
  } lb_cmd_t;

  typedef struct packed {
    logic                     wr;
    logic [LB_PKG_DATA_W-1:0] rdata;
    logic                     err;
  } lb_rsp_t;

endpackage

// File: rtl/lb_host_master_tmr.sv
// lb_mstr_tmr: load/run/expire counter for the host master timeout.
// It is built only when LB_TIMEOUT_EN is defined.
//   clk, rst  : clock, asynchronous active-high reset
//   load_i    : clear the count to 0
//   run_i     : increment the count; it holds once it has expired
//   expire_o  : the count has reached LIMIT
module lb_mstr_tmr #(
  parameter int unsigned TMR_W = 16,
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);

  logic [TMR_W-1:0] cnt_q;

  assign expire_o = (cnt_q == TMR_W'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (run_i && !expire_o) begin
      cnt_q <= cnt_q + TMR_W'(1);
    end
  end

endmodule

// File: rtl/lb_host_master.sv
// lb_host_master: local-bus initiator. It turns a valid/ready command stream into
// single lb_wr_en/lb_rd_en strobes and returns one response per command. Only one
// transaction is outstanding at a time.
// Optional feature: defining LB_TIMEOUT_EN adds a timeout. If the access is not
// completed TIMEOUT_CYC cycles after the strobe, the response has rsp_err=1.
// Ports:
//   clk, rst                           clock, asynchronous active-high reset
//   cmd_valid/cmd_ready                command handshake (cmd_ready registered)
//   cmd_wr, cmd_addr, cmd_wdata        command fields
//   rsp_valid/rsp_ready                response handshake (held until consumed)
//   rsp_wr, rsp_rdata, rsp_err         response fields
//   stray_flag                         sticky: unexpected lb_*_valid seen
//   lb_wr_en, lb_rd_en                 1-cycle access strobes
//   lb_addr, lb_wr_data                held from the strobe until completion
//   lb_wr_valid, lb_rd_valid, lb_rd_data  slave completion and read data
module lb_host_master
  import lb_host_master_pkg::*;
#(
  parameter int unsigned          LB_DATA_W        = 32,
  parameter int unsigned          LB_ADDR_W        = 16,
  parameter int unsigned          TIMEOUT_CYC      = 256,
  parameter logic [LB_DATA_W-1:0] DEFAULT_DATA_VAL = 'hdeadbabe
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic [LB_ADDR_W-1:0] cmd_addr,
  input  logic [LB_DATA_W-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_wr,
  output logic [LB_DATA_W-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 stray_flag,
  output logic                 lb_wr_en,
  output logic                 lb_rd_en,
  output logic [LB_ADDR_W-1:0] lb_addr,
  output logic [LB_DATA_W-1:0] lb_wr_data,
  input  logic                 lb_wr_valid,
  input  logic                 lb_rd_valid,
  input  logic [LB_DATA_W-1:0] lb_rd_data
);

  lb_state_e state_q;
  lb_cmd_t   cmd_q;
  lb_rsp_t   rsp_q;
  logic      cmd_ready_q;
  logic      rsp_valid_q;
  logic      lb_wr_en_q;
  logic      lb_rd_en_q;
  logic      stray_q;

  logic      busy;
  logic      done;
  logic      stray_hit;
  logic      tmr_expire;

  // Only the valid that matches the access type completes it. Any other valid
  // is stray. This includes every valid seen in IDLE or RESP.
  always_comb begin
    busy      = (state_q == ISSUE) || (state_q == WAIT);
    done      = 1'b0;
    stray_hit = lb_wr_valid || lb_rd_valid;
    if (busy) begin
      done      = cmd_q.wr ? lb_wr_valid : lb_rd_valid;
      stray_hit = cmd_q.wr ? lb_rd_valid : lb_wr_valid;
    end
  end

`ifdef LB_TIMEOUT_EN
  logic tmr_load;
  logic tmr_run;

  // The count is 0 during the strobe cycle and advances at every following
  // edge, so expiry lands TIMEOUT_CYC cycles after the strobe.
  assign tmr_load = (state_q == IDLE);
  assign tmr_run  = busy;

  lb_mstr_tmr #(
    .TMR_W (TMR_W),
    .LIMIT (TIMEOUT_CYC)
  ) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .run_i    (tmr_run),
    .expire_o (tmr_expire)
  );
`else
  assign tmr_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      lb_wr_en_q  <= 1'b0;
      lb_rd_en_q  <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      lb_wr_en_q <= 1'b0;
      lb_rd_en_q <= 1'b0;
      if (stray_hit) begin
        stray_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_q.wr    <= cmd_wr;
            cmd_q.addr  <= LB_PKG_ADDR_W'(cmd_addr);
            cmd_q.wdata <= LB_PKG_DATA_W'(cmd_wdata);
            lb_wr_en_q  <= cmd_wr;
            lb_rd_en_q  <= !cmd_wr;
            cmd_ready_q <= 1'b0;
            state_q     <= ISSUE;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ISSUE, WAIT: begin
          // A completion that arrives together with expiry takes priority.
          if (done) begin
            rsp_q.wr    <= cmd_q.wr;
            rsp_q.rdata <= cmd_q.wr ? '0 : LB_PKG_DATA_W'(lb_rd_data);
            rsp_q.err   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if ((state_q == WAIT) && tmr_expire) begin
            rsp_q.wr    <= cmd_q.wr;
            rsp_q.rdata <= cmd_q.wr ? '0 : LB_PKG_DATA_W'(DEFAULT_DATA_VAL);
            rsp_q.err   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_wr     = rsp_q.wr;
  assign rsp_rdata  = LB_DATA_W'(rsp_q.rdata);
  assign rsp_err    = rsp_q.err;
  assign stray_flag = stray_q;
  assign lb_wr_en   = lb_wr_en_q;
  assign lb_rd_en   = lb_rd_en_q;
  assign lb_addr    = LB_ADDR_W'(cmd_q.addr);
  assign lb_wr_data = LB_DATA_W'(cmd_q.wdata);

endmodule

// File: tb/tb_lb_host_master.sv
// Directed bench for lb_host_master. Expected responses are queued as each
// command is driven and compared when the response appears. Builds with
// LB_TIMEOUT_EN also exercise the timeout path (TIMEOUT_CYC=8).
module tb_lb_host_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_wr;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stray_flag;
  logic        lb_wr_en;
  logic        lb_rd_en;
  logic [15:0] lb_addr;
  logic [31:0] lb_wr_data;
  logic        lb_wr_valid = 1'b0;
  logic        lb_rd_valid = 1'b0;
  logic [31:0] lb_rd_data = '0;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  lb_host_master #(
    .LB_DATA_W        (32),
    .LB_ADDR_W        (16),
    .TIMEOUT_CYC      (8),
    .DEFAULT_DATA_VAL (32'hdeadbabe)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_wr      (rsp_wr),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .stray_flag  (stray_flag),
    .lb_wr_en    (lb_wr_en),
    .lb_rd_en    (lb_rd_en),
    .lb_addr     (lb_addr),
    .lb_wr_data  (lb_wr_data),
    .lb_wr_valid (lb_wr_valid),
    .lb_rd_valid (lb_rd_valid),
    .lb_rd_data  (lb_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic wr, input logic [15:0] a, input logic [31:0] d);
    int unsigned n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic await_rsp(input int unsigned budget);
    int unsigned n = 0;
    while (rsp_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("rsp_arrive", rsp_valid, 1);
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_wr"}, rsp_wr, e.wr);
      chk({tag, "_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_err"}, rsp_err, e.err);
    end
  endtask

  initial begin
    int unsigned t_acc;
    int unsigned t_prev;
    logic [31:0] rd_val;

    // Reset state
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_strobes", {lb_wr_en, lb_rd_en}, 0);
    chk("rst_stray", stray_flag, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // 1: write; the slave completes 2 cycles after the strobe
    exp_q.push_back('{wr: 1'b1, rdata: 32'h0, err: 1'b0});
    send(1'b1, 16'h0010, 32'h12345678);
    chk("t1_wr_en", lb_wr_en, 1);
    chk("t1_rd_en", lb_rd_en, 0);
    chk("t1_addr", lb_addr, 16'h0010);
    chk("t1_wdata", lb_wr_data, 32'h12345678);
    chk("t1_cmd_ready_busy", cmd_ready, 0);
    tick();
    chk("t1_wr_en_pulse", lb_wr_en, 0);
    chk("t1_addr_held", lb_addr, 16'h0010);
    chk("t1_wdata_held", lb_wr_data, 32'h12345678);
    tick();
    chk("t1_no_rsp_yet", rsp_valid, 0);
    lb_wr_valid = 1'b1;
    tick();
    lb_wr_valid = 1'b0;
    await_rsp(0);
    check_rsp("t1");
    tick();
    chk("t1_rsp_done", rsp_valid, 0);
    chk("t1_cmd_ready", cmd_ready, 1);
    chk("t1_stray", stray_flag, 0);

    // 2: back-to-back reads against a combinational slave
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      rd_val = 32'hCAFEF00D + 32'(i);
      exp_q.push_back('{wr: 1'b0, rdata: rd_val, err: 1'b0});
      send(1'b0, 16'h0020 + 16'(i), 32'h0);
      t_acc = cyc;
      if (i != 0) chk("t2_cadence", t_acc - t_prev, 3);
      t_prev = t_acc;
      chk("t2_rd_en", lb_rd_en, 1);
      chk("t2_addr", lb_addr, 16'h0020 + 16'(i));
      lb_rd_valid = 1'b1;
      lb_rd_data  = rd_val;
      tick();
      lb_rd_valid = 1'b0;
      lb_rd_data  = 32'h0;
      await_rsp(0);
      check_rsp("t2");
      tick();
    end
    chk("t2_stray", stray_flag, 0);

    // 3: response back-pressure; a second command must wait
    rsp_ready = 1'b0;
    exp_q.push_back('{wr: 1'b0, rdata: 32'hA5A55A5A, err: 1'b0});
    send(1'b0, 16'h0030, 32'h0);
    lb_rd_valid = 1'b1;
    lb_rd_data  = 32'hA5A55A5A;
    tick();
    lb_rd_valid = 1'b0;
    lb_rd_data  = 32'h0;
    await_rsp(0);
    check_rsp("t3");
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 16'h0040;
    cmd_wdata = 32'h00000099;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_rdata", rsp_rdata, 32'hA5A55A5A);
      chk("t3_hold_wr", rsp_wr, 0);
      chk("t3_cmd_ready", cmd_ready, 0);
      chk("t3_no_strobe", {lb_wr_en, lb_rd_en}, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("t3_released", rsp_valid, 0);
    chk("t3_idle_ready", cmd_ready, 1);
    chk("t3_not_issued", lb_wr_en, 0);

    // 5: wrong-type valid during a write is stray; the write valid completes it
    exp_q.push_back('{wr: 1'b1, rdata: 32'h0, err: 1'b0});
    send(1'b1, 16'h0050, 32'h11112222);
    tick();
    lb_rd_valid = 1'b1;
    tick();
    lb_rd_valid = 1'b0;
    chk("t5_stray_set", stray_flag, 1);
    chk("t5_still_wait", rsp_valid, 0);
    tick();
    chk("t5_still_wait2", rsp_valid, 0);
    lb_wr_valid = 1'b1;
    tick();
    lb_wr_valid = 1'b0;
    await_rsp(0);
    check_rsp("t5");
    tick();
    chk("t5_stray_sticky", stray_flag, 1);

    // 6: reset while waiting aborts with no response
    send(1'b0, 16'h0060, 32'h0);
    chk("t6_rd_en", lb_rd_en, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_async_rsp_valid", rsp_valid, 0);
    chk("t6_async_cmd_ready", cmd_ready, 0);
    chk("t6_async_strobes", {lb_wr_en, lb_rd_en}, 0);
    chk("t6_stray_cleared", stray_flag, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("t6_cmd_ready", cmd_ready, 1);
    tick();
    tick();
    chk("t6_no_rsp", rsp_valid, 0);
    chk("t6_sb_empty", exp_q.size(), 0);

`ifdef LB_TIMEOUT_EN
    // 4: silent slave times out; a late valid is stray
    exp_q.push_back('{wr: 1'b0, rdata: 32'hdeadbabe, err: 1'b1});
    send(1'b0, 16'h0070, 32'h0);
    t_acc = cyc;
    await_rsp(20);
    chk("t4_latency", ((cyc - t_acc) >= 9) && ((cyc - t_acc) <= 10), 1);
    check_rsp("t4");
    tick();
    chk("t4_stray_before", stray_flag, 0);
    lb_rd_valid = 1'b1;
    tick();
    lb_rd_valid = 1'b0;
    chk("t4_late_stray", stray_flag, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
